// File: rtl/reg_dump_sequencer_pkg.sv
// Shared debug definitions: the dump FSM state encoding, the word/byte geometry
// and the register-file address width used by the debug read port.
package reg_dump_sequencer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        SEND = ST_SEND,
        DONE = ST_DONE
    } dump_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
    localparam int REG_ADDR_W     = 5;

endpackage

// File: rtl/reg_dump_sequencer.sv
// Walks the register file through its debug read port and streams every
// 32-bit register out as four bytes on a valid/ready channel, then pulses done.
module reg_dump_sequencer
    import reg_dump_sequencer_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [REG_ADDR_W-1:0] du_reg_addr,
    input  logic [31:0]           du_reg_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  halt_req,
    output logic                  done
);

    localparam logic [REG_ADDR_W-1:0] LAST_REG  = REG_ADDR_W'(NUM_REGS - 1);
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    dump_state_t             r_state;
    dump_state_t             w_state_next;
    logic [REG_ADDR_W-1:0]   r_reg_idx;
    logic [REG_ADDR_W-1:0]   w_reg_idx_next;
    logic [BYTE_IDX_W-1:0]   r_byte_idx;
    logic [BYTE_IDX_W-1:0]   w_byte_idx_next;
    logic [31:0]             r_shift;
    logic [31:0]             w_shift_next;
    logic [REG_ADDR_W-1:0]   r_du_reg_addr;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_accept;
    logic [BYTE_IDX_W-1:0]   w_byte_sel;
    logic [7:0]              w_tx_byte;

    assign w_accept = tx_valid && tx_ready;

    always_comb begin
        w_state_next    = r_state;
        w_reg_idx_next  = r_reg_idx;
        w_byte_idx_next = r_byte_idx;
        w_shift_next    = r_shift;
        case (r_state)
            IDLE: begin
                w_reg_idx_next  = '0;
                w_byte_idx_next = '0;
                if (start) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_shift_next    = du_reg_data;
                w_byte_idx_next = '0;
                w_state_next    = SEND;
            end
            SEND: begin
                if (w_accept) begin
                    if (r_byte_idx == LAST_BYTE) begin
                        if (r_reg_idx == LAST_REG) begin
                            w_state_next = DONE;
                        end else begin
                            w_reg_idx_next = r_reg_idx + 1'b1;
                            w_state_next   = LOAD;
                        end
                    end else begin
                        w_byte_idx_next = r_byte_idx + 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // busy/done/address are registered from the next-state view so they line
    // up with the state they describe without any combinational output path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_reg_idx     <= '0;
            r_byte_idx    <= '0;
            r_shift       <= '0;
            r_du_reg_addr <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_reg_idx     <= w_reg_idx_next;
            r_byte_idx    <= w_byte_idx_next;
            r_shift       <= w_shift_next;
            r_du_reg_addr <= w_reg_idx_next;
            r_busy        <= (w_state_next != IDLE);
            r_done        <= (w_state_next == DONE);
        end
    end

    always_comb begin
        w_byte_sel = MSB_FIRST ? (LAST_BYTE - r_byte_idx) : r_byte_idx;
        case (w_byte_sel)
            2'd0:    w_tx_byte = r_shift[7:0];
            2'd1:    w_tx_byte = r_shift[15:8];
            2'd2:    w_tx_byte = r_shift[23:16];
            default: w_tx_byte = r_shift[31:24];
        endcase
        // Keep the channel quiet outside SEND so idle and reset both show zero.
        if (r_state != SEND) begin
            w_tx_byte = 8'h00;
        end
    end

    assign tx_valid    = (r_state == SEND);
    assign tx_data     = w_tx_byte;
    assign du_reg_addr = r_du_reg_addr;
    assign busy        = r_busy;
    assign halt_req    = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Randomized bench for reg_dump_sequencer: three instances (32 regs MSB-first,
// 32 regs LSB-first, 1 reg) checked against a byte-stream model of each dump.
module tb_reg_dump_sequencer;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_s    [NI];
    logic        tx_ready_s [NI];
    logic        tx_valid_s [NI];
    logic        busy_s     [NI];
    logic        halt_s     [NI];
    logic        done_s     [NI];
    logic [4:0]  addr_s     [NI];
    logic [31:0] rdata_s    [NI];
    logic [7:0]  txd_s      [NI];
    logic [31:0] regfile    [NI][32];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            assign rdata_s[gi] = regfile[gi][addr_s[gi]];
            reg_dump_sequencer #(
                .NUM_REGS  ((gi == 2) ? 1 : 32),
                .MSB_FIRST ((gi == 1) ? 1'b0 : 1'b1)
            ) u_dut (
                .clk         (clk),
                .reset       (reset),
                .start       (start_s[gi]),
                .du_reg_addr (addr_s[gi]),
                .du_reg_data (rdata_s[gi]),
                .tx_data     (txd_s[gi]),
                .tx_valid    (tx_valid_s[gi]),
                .tx_ready    (tx_ready_s[gi]),
                .busy        (busy_s[gi]),
                .halt_req    (halt_s[gi]),
                .done        (done_s[gi])
            );
        end
    endgenerate

    function automatic int num_regs_of(input int k);
        return (k == 2) ? 1 : 32;
    endfunction

    function automatic bit msb_first_of(input int k);
        return (k != 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input int k, input string tag);
        check({tag, "_tx_valid"}, 32'(tx_valid_s[k]), 32'd0);
        check({tag, "_busy"},     32'(busy_s[k]),     32'd0);
        check({tag, "_halt_req"}, 32'(halt_s[k]),     32'd0);
        check({tag, "_done"},     32'(done_s[k]),     32'd0);
    endtask

    // Runs one dump on instance k. pct is the tx_ready duty in percent,
    // restart_cyc re-pulses start mid-dump, reset_cyc aborts with reset.
    task automatic run_dump(input int k, input int pct, input int restart_cyc, input int reset_cyc);
        int         n;
        int         cyc;
        int         stalls;
        int         exp_done;
        int         done_cnt;
        int         sh;
        bit         fin;
        logic       pv;
        logic       pr;
        logic [7:0] pd;
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        n = num_regs_of(k);
        for (int r = 0; r < n; r++) begin
            for (int b = 0; b < 4; b++) begin
                sh = msb_first_of(k) ? 8 * (3 - b) : 8 * b;
                exp_q.push_back(8'(regfile[k][r] >> sh));
            end
        end
        @(negedge clk);
        start_s[k]    = 1'b1;
        tx_ready_s[k] = 1'b0;
        @(negedge clk);
        start_s[k] = 1'b0;
        cyc = 1; stalls = 0; done_cnt = 0; fin = 0;
        pv = 1'b0; pr = 1'b0; pd = 8'h00;
        while (!fin) begin
            if (cyc == reset_cyc) begin
                reset = 1'b1;
                #1;
                check_quiet(k, "reset_mid");
                check("reset_mid_addr", 32'(addr_s[k]), 32'd0);
                check("reset_mid_data", 32'(txd_s[k]), 32'd0);
                tx_ready_s[k] = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                $display("dump inst=%0d aborted by reset at cycle %0d after %0d bytes", k, cyc, got_q.size());
                return;
            end
            exp_done = 5 * n + 1 + stalls;
            check("busy",     32'(busy_s[k]), 32'(cyc <= exp_done));
            check("halt_req", 32'(halt_s[k]), 32'(cyc <= exp_done));
            check("done",     32'(done_s[k]), 32'(cyc == exp_done));
            if (cyc == 1) check("load_no_valid", 32'(tx_valid_s[k]), 32'd0);
            if (cyc == 2) check("first_valid",   32'(tx_valid_s[k]), 32'd1);
            if (n == 1)   check("addr_fixed",    32'(addr_s[k]),     32'd0);
            if (pv && !pr) begin
                check("hold_valid", 32'(tx_valid_s[k]), 32'd1);
                check("hold_data",  32'(txd_s[k]),      32'(pd));
            end
            if (done_s[k]) done_cnt++;
            if (cyc > exp_done) fin = 1;
            if (cyc >= 3000) begin
                check("timeout", 32'(cyc), 32'(exp_done));
                fin = 1;
            end
            start_s[k]    = (cyc == restart_cyc);
            tx_ready_s[k] = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
            if (tx_valid_s[k] && tx_ready_s[k])  got_q.push_back(txd_s[k]);
            if (tx_valid_s[k] && !tx_ready_s[k]) stalls++;
            pv = tx_valid_s[k]; pr = tx_ready_s[k]; pd = txd_s[k];
            @(negedge clk);
            cyc++;
        end
        tx_ready_s[k] = 1'b0;
        start_s[k]    = 1'b0;
        check("done_count", 32'(done_cnt), 32'd1);
        check("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        for (int i = 0; i < 3; i++) begin
            check_quiet(k, "post_idle");
            @(negedge clk);
        end
        $display("dump inst=%0d regs=%0d ready=%0d%% bytes=%0d done_cycle=%0d stalls=%0d",
                 k, n, pct, got_q.size(), exp_done, stalls);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            start_s[k]    = 1'b0;
            tx_ready_s[k] = 1'b0;
            for (int r = 0; r < 32; r++) regfile[k][r] = $urandom;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check_quiet(k, "reset");
            check("reset_addr", 32'(addr_s[k]), 32'd0);
            check("reset_data", 32'(txd_s[k]),  32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Known pattern with full-rate ready: done lands at T+161.
        for (int r = 0; r < 32; r++) regfile[0][r] = 32'h0100_0000 + 32'(r);
        run_dump(0, 100, -1, -1);

        // Same pattern under a 30% ready duty, with a start re-pulse mid-dump.
        run_dump(0, 30, 40, -1);

        // Random contents, random duty.
        for (int r = 0; r < 32; r++) regfile[0][r] = $urandom;
        run_dump(0, 60, -1, -1);

        // Abort with reset, confirm quiet, then a fresh dump restarts at r0.
        run_dump(0, 100, -1, 50);
        for (int i = 0; i < 4; i++) begin
            check_quiet(0, "after_reset");
            @(negedge clk);
        end
        for (int r = 0; r < 32; r++) regfile[0][r] = $urandom;
        run_dump(0, 50, -1, -1);

        // LSB-first instance with r5 = DEADBEEF.
        regfile[1][5] = 32'hDEAD_BEEF;
        run_dump(1, 100, -1, -1);
        run_dump(1, 40, -1, -1);

        // Single-register instance.
        regfile[2][0] = 32'h1234_5678;
        run_dump(2, 100, -1, -1);
        regfile[2][0] = $urandom;
        run_dump(2, 30, 3, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_dump_sequencer.md
# reg_dump_sequencer

Debug-side sequencer that reads the ID-stage register file through its debug read port and streams every register out as bytes over a valid/ready byte channel toward the debug unit's UART transmitter. On a start pulse it walks register addresses 0..NUM_REGS-1, captures each 32-bit value and emits it as four bytes, then pulses done. It is the direct consumer of the register file's debug read port and requests a pipeline halt for the whole dump.

## Interface
- NUM_REGS, 32, registers dumped, addresses 0..NUM_REGS-1; range 1..32
- MSB_FIRST, 1, 1: byte 3 (bits 31:24) sent first; 0: byte 0 first
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle dump request; ignored while busy
- du_reg_addr  out  5  register file debug read address
- du_reg_data  in  32  combinational read data for du_reg_addr
- tx_data  out  8  byte to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data this cycle
- busy  out  1  dump in progress
- halt_req  out  1  pipeline halt request; equals busy
- done  out  1  one-cycle pulse after last byte is accepted

## Operation
- States: IDLE, LOAD, SEND, DONE.
- IDLE: reg_idx=0, byte_idx=0. start=1 -> LOAD; busy rises next cycle.
- LOAD: du_reg_addr=reg_idx, stable since the previous cycle; capture du_reg_data into a 32-bit shift register; byte_idx=0 -> SEND.
- SEND: tx_valid=1, tx_data = selected byte per MSB_FIRST. On tx_valid&&tx_ready: byte_idx==3 -> if reg_idx==NUM_REGS-1 -> DONE, else reg_idx+1 -> LOAD; otherwise byte_idx+1, stay.
- DONE: done=1 for one cycle -> IDLE; busy falls with the return to IDLE.
- start while busy: ignored, not queued. start in the DONE cycle: ignored.
- tx_data and tx_valid do not change while tx_valid=1 and tx_ready=0.
- reg_idx is 5 bits; never wraps past NUM_REGS-1.
- The register file writes on negedge; a value written before the LOAD posedge is captured. The halt keeps WB writes from changing registers mid-dump, but the sequencer does not depend on that.

## Timing
- Reset: state=IDLE, du_reg_addr=0, tx_data=0, tx_valid=0, busy=0, halt_req=0, done=0, counters and shift register=0.
- Reset mid-dump: all outputs return to reset values at once, including tx_valid dropping without a handshake; no done pulse.
- start accepted at edge T -> LOAD in cycle T+1 -> first tx_valid in cycle T+2.
- tx_ready held high: 5 cycles per register; last byte accepted at T+5·NUM_REGS; done at T+5·NUM_REGS+1. That is cycle T+161 for NUM_REGS=32.
- Each cycle tx_ready=0 during SEND adds exactly one cycle.
- Outputs are registered except tx_data/tx_valid, which are decoded from state and shift register with no input-to-output combinational path. du_reg_addr is a register.

## Structure
- Shared debug package holds: the state encoding localparams (IDLE/LOAD/SEND/DONE), the BYTES_PER_WORD=4 constant, and the register address width 5.
- Single module, no sub-modules. Byte selection is an inline mux on byte_idx.

## Test plan
- Reset, then preload register r=0x01000000+r for all r, tx_ready=1, pulse start -> 128 bytes 01,00,00,00,01,00,00,01,...; done exactly at T+161; busy high for T+1..T+161.
- MSB_FIRST=0, r5=0xDEADBEEF -> bytes for r5 are EF,BE,AD,DE.
- tx_ready random 30% duty -> byte stream identical to the 100% case; tx_data stable whenever valid&&!ready.
- start pulsed again at T+40 -> ignored; exactly 128 bytes and one done.
- Reset asserted at T+50 -> tx_valid, busy and halt_req are 0 immediately; no done; a new start dumps from r0.
- NUM_REGS=1, r0=0x12345678 -> 12,34,56,78; done at T+6; du_reg_addr never leaves 0.
